// File: rtl/cdb_arbiter.sv
// Round-robin arbiter sharing two common data buses among NUM_FU result ports.
// Optional macro CDB_MISPRED_PRIORITY_EN scans mispredicted results ahead of the rest.
module cdb_arbiter #(
  parameter int NUM_FU = 4,
  parameter int PTR_W  = 2
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 flush_in,
  input  logic [NUM_FU-1:0]    fu_valid_in,
  input  logic [NUM_FU*8-1:0]  fu_tag_in,
  input  logic [NUM_FU*64-1:0] fu_value_in,
  input  logic [NUM_FU-1:0]    fu_mispredicted_in,
  output logic [NUM_FU-1:0]    fu_ready_out,
  output logic [7:0]           cdb1_tag_out,
  output logic [63:0]          cdb1_value_out,
  output logic                 cdb1_mispredicted_out,
  output logic [7:0]           cdb2_tag_out,
  output logic [63:0]          cdb2_value_out,
  output logic                 cdb2_mispredicted_out,
  output logic                 busy_out
);

  localparam logic [7:0] NULL_TAG = 8'hFF;

  logic [7:0]        tag_arr   [NUM_FU];
  logic [63:0]       value_arr [NUM_FU];
  logic [NUM_FU-1:0] eligible;
  logic [NUM_FU-1:0] scan_mask [2];
  logic [PTR_W-1:0]  rr_ptr;
  logic [PTR_W-1:0]  grant_a_idx, grant_b_idx;
  logic              grant_a_vld, grant_b_vld;
  logic              take;

  for (genvar i = 0; i < NUM_FU; i++) begin : g_unpack
    assign tag_arr[i]   = fu_tag_in[i*8 +: 8];
    assign value_arr[i] = fu_value_in[i*64 +: 64];
    assign eligible[i]  = fu_valid_in[i] && (tag_arr[i] != NULL_TAG);
  end

  // Two scan passes; without priority the second pass has nothing to find.
  always_comb begin
`ifdef CDB_MISPRED_PRIORITY_EN
    scan_mask[0] = eligible & fu_mispredicted_in;
    scan_mask[1] = eligible & ~fu_mispredicted_in;
`else
    scan_mask[0] = eligible;
    scan_mask[1] = '0;
`endif
  end

  always_comb begin
    grant_a_vld = 1'b0;
    grant_b_vld = 1'b0;
    grant_a_idx = '0;
    grant_b_idx = '0;
    for (int p = 0; p < 2; p++) begin
      for (int k = 0; k < NUM_FU; k++) begin
        int sum;
        sum = int'(rr_ptr) + k;
        if (sum >= NUM_FU) sum = sum - NUM_FU;
        if (scan_mask[p][sum]) begin
          if (!grant_a_vld) begin
            grant_a_vld = 1'b1;
            grant_a_idx = PTR_W'(sum);
          end else if (!grant_b_vld) begin
            grant_b_vld = 1'b1;
            grant_b_idx = PTR_W'(sum);
          end
        end
      end
    end
  end

  assign take = reset && !flush_in;

  always_comb begin
    fu_ready_out = '0;
    if (take) begin
      if (grant_a_vld) fu_ready_out[grant_a_idx] = 1'b1;
      if (grant_b_vld) fu_ready_out[grant_b_idx] = 1'b1;
    end
  end

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] idx);
    return (idx == PTR_W'(NUM_FU - 1)) ? '0 : idx + 1'b1;
  endfunction

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rr_ptr <= '0;
    end else if (!flush_in) begin
      if (grant_b_vld)      rr_ptr <= ptr_inc(grant_b_idx);
      else if (grant_a_vld) rr_ptr <= ptr_inc(grant_a_idx);
    end
  end

  // Granted tags are never NULL_TAG, so busy follows grant A directly.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cdb1_tag_out          <= NULL_TAG;
      cdb1_value_out        <= '0;
      cdb1_mispredicted_out <= 1'b0;
      cdb2_tag_out          <= NULL_TAG;
      cdb2_value_out        <= '0;
      cdb2_mispredicted_out <= 1'b0;
      busy_out              <= 1'b0;
    end else begin
      cdb1_tag_out          <= NULL_TAG;
      cdb1_value_out        <= '0;
      cdb1_mispredicted_out <= 1'b0;
      cdb2_tag_out          <= NULL_TAG;
      cdb2_value_out        <= '0;
      cdb2_mispredicted_out <= 1'b0;
      busy_out              <= 1'b0;
      if (!flush_in && grant_a_vld) begin
        cdb1_tag_out          <= tag_arr[grant_a_idx];
        cdb1_value_out        <= value_arr[grant_a_idx];
        cdb1_mispredicted_out <= fu_mispredicted_in[grant_a_idx];
        busy_out              <= 1'b1;
      end
      if (!flush_in && grant_b_vld) begin
        cdb2_tag_out          <= tag_arr[grant_b_idx];
        cdb2_value_out        <= value_arr[grant_b_idx];
        cdb2_mispredicted_out <= fu_mispredicted_in[grant_b_idx];
      end
    end
  end

endmodule

// File: tb/tb_cdb_arbiter.sv
// Directed-vector bench for cdb_arbiter with NUM_FU=4.
module tb_cdb_arbiter;

  logic         clock = 1'b0;
  logic         reset;
  logic         flush_in;
  logic [3:0]   fu_valid;
  logic [31:0]  fu_tag;
  logic [255:0] fu_value;
  logic [3:0]   fu_mp;
  logic [3:0]   fu_ready;
  logic [7:0]   c1_tag, c2_tag;
  logic [63:0]  c1_val, c2_val;
  logic         c1_mp, c2_mp;
  logic         busy;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clock = ~clock;

  cdb_arbiter #(.NUM_FU(4), .PTR_W(2)) dut (
    .clock                 (clock),
    .reset                 (reset),
    .flush_in              (flush_in),
    .fu_valid_in           (fu_valid),
    .fu_tag_in             (fu_tag),
    .fu_value_in           (fu_value),
    .fu_mispredicted_in    (fu_mp),
    .fu_ready_out          (fu_ready),
    .cdb1_tag_out          (c1_tag),
    .cdb1_value_out        (c1_val),
    .cdb1_mispredicted_out (c1_mp),
    .cdb2_tag_out          (c2_tag),
    .cdb2_value_out        (c2_val),
    .cdb2_mispredicted_out (c2_mp),
    .busy_out              (busy)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] val_of(input logic [7:0] t);
    return 64'hA5C3_0000_0000_0000 | {56'h0, t};
  endfunction

  task automatic set_fu(input int i, input logic v, input logic [7:0] t, input logic m);
    fu_valid[i]         = v;
    fu_tag[i*8 +: 8]    = t;
    fu_value[i*64 +: 64] = val_of(t);
    fu_mp[i]            = m;
  endtask

  task automatic clr_all();
    for (int i = 0; i < 4; i++) set_fu(i, 1'b0, 8'h00, 1'b0);
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check_cdb(input string nm, input logic [7:0] t1, input logic m1,
                           input logic [7:0] t2, input logic m2);
    check({nm, "_c1tag"}, 64'(c1_tag), 64'(t1));
    check({nm, "_c1val"}, c1_val, (t1 == 8'hFF) ? 64'h0 : val_of(t1));
    check({nm, "_c1mp"},  64'(c1_mp), 64'(m1));
    check({nm, "_c2tag"}, 64'(c2_tag), 64'(t2));
    check({nm, "_c2val"}, c2_val, (t2 == 8'hFF) ? 64'h0 : val_of(t2));
    check({nm, "_c2mp"},  64'(c2_mp), 64'(m2));
    check({nm, "_busy"},  64'(busy), 64'(t1 != 8'hFF || t2 != 8'hFF));
  endtask

  initial begin
    reset    = 1'b0;
    flush_in = 1'b0;
    clr_all();
    set_fu(0, 1'b1, 8'h01, 1'b0);
    #1;
    check("rst_ready", 64'(fu_ready), 64'h0);
    #6;
    clr_all();
    #1;
    reset = 1'b1;
    #1;
    // 1: idle after reset
    check("t1_ready", 64'(fu_ready), 64'h0);
    check_cdb("t1", 8'hFF, 1'b0, 8'hFF, 1'b0);
    check("t1_ptr", 64'(dut.rr_ptr), 64'd0);
    tick();
    check_cdb("t1b", 8'hFF, 1'b0, 8'hFF, 1'b0);

    // 2: valid=1011 from ptr 0
    set_fu(0, 1'b1, 8'h03, 1'b0);
    set_fu(1, 1'b1, 8'h07, 1'b0);
    set_fu(2, 1'b0, 8'h44, 1'b0);
    set_fu(3, 1'b1, 8'h09, 1'b0);
    #1;
    check("t2_ready", 64'(fu_ready), 64'b0011);
    tick();
    check_cdb("t2", 8'h03, 1'b0, 8'h07, 1'b0);
    check("t2_ptr", 64'(dut.rr_ptr), 64'd2);
    set_fu(0, 1'b0, 8'h03, 1'b0);
    set_fu(1, 1'b0, 8'h07, 1'b0);
    #1;
    check("t2b_ready", 64'(fu_ready), 64'b1000);
    tick();
    check_cdb("t2b", 8'h09, 1'b0, 8'hFF, 1'b0);
    check("t2b_ptr", 64'(dut.rr_ptr), 64'd0);
    clr_all();
    tick();
    check_cdb("t2c", 8'hFF, 1'b0, 8'hFF, 1'b0);
    check("t2c_ptr", 64'(dut.rr_ptr), 64'd0);

    // 3: bring ptr to 3, then wrap
    set_fu(2, 1'b1, 8'h20, 1'b0);
    tick();
    check("t3_pre_ptr", 64'(dut.rr_ptr), 64'd3);
    clr_all();
    set_fu(0, 1'b1, 8'h12, 1'b0);
    set_fu(3, 1'b1, 8'h1F, 1'b0);
    #1;
    check("t3_ready", 64'(fu_ready), 64'b1001);
    tick();
    check_cdb("t3", 8'h1F, 1'b0, 8'h12, 1'b0);
    check("t3_ptr", 64'(dut.rr_ptr), 64'd1);

    // 4: flush with all valid
    for (int i = 0; i < 4; i++) set_fu(i, 1'b1, 8'(8'h10 + i), 1'b0);
    flush_in = 1'b1;
    #1;
    check("t4_ready", 64'(fu_ready), 64'h0);
    tick();
    check_cdb("t4", 8'hFF, 1'b0, 8'hFF, 1'b0);
    check("t4_ptr", 64'(dut.rr_ptr), 64'd1);
    flush_in = 1'b0;
    #1;
    check("t4b_ready", 64'(fu_ready), 64'b0110);
    tick();
    check_cdb("t4b", 8'h11, 1'b0, 8'h12, 1'b0);
    check("t4b_ptr", 64'(dut.rr_ptr), 64'd3);

    // 5: null tag is ignored
    clr_all();
    set_fu(2, 1'b1, 8'hFF, 1'b0);
    set_fu(1, 1'b1, 8'h05, 1'b0);
    #1;
    check("t5_ready", 64'(fu_ready), 64'b0010);
    tick();
    check_cdb("t5", 8'h05, 1'b0, 8'hFF, 1'b0);
    check("t5_ptr", 64'(dut.rr_ptr), 64'd2);

    // 6: mispredict handling from ptr 0
    clr_all();
    set_fu(3, 1'b1, 8'h30, 1'b0);
    tick();
    check("t6_pre_ptr", 64'(dut.rr_ptr), 64'd0);
    clr_all();
    set_fu(0, 1'b1, 8'h40, 1'b0);
    set_fu(2, 1'b1, 8'h42, 1'b1);
    #1;
    check("t6_ready", 64'(fu_ready), 64'b0101);
    tick();
`ifdef CDB_MISPRED_PRIORITY_EN
    check_cdb("t6", 8'h42, 1'b1, 8'h40, 1'b0);
    check("t6_ptr", 64'(dut.rr_ptr), 64'd1);
`else
    check_cdb("t6", 8'h40, 1'b0, 8'h42, 1'b1);
    check("t6_ptr", 64'(dut.rr_ptr), 64'd3);
`endif

    // 7: async reset mid-operation
    clr_all();
    set_fu(1, 1'b1, 8'h55, 1'b0);
    set_fu(2, 1'b1, 8'h66, 1'b0);
    tick();
    check("t7_pre_busy", 64'(busy), 64'd1);
    #2;
    reset = 1'b0;
    #1;
    check_cdb("t7", 8'hFF, 1'b0, 8'hFF, 1'b0);
    check("t7_ready", 64'(fu_ready), 64'h0);
    check("t7_ptr", 64'(dut.rr_ptr), 64'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/cdb_arbiter.md
Name: cdb_arbiter

Overview:
- Shares the two common data buses (CDB1/CDB2) among NUM_FU functional-unit result ports.
- Each cycle grants up to two pending results, round-robin, using a valid/ready handshake. Granted results are registered onto the CDB outputs.
- The CDB outputs feed the reorder buffer entries and reservation stations (tag/value/mispredicted broadcast).
- A flush input discards in-flight broadcasts on branch-mispredict recovery.

Parameters:
- NUM_FU, 4: number of requesting functional units (2..8).
- PTR_W, 2: round-robin pointer width; must equal clog2(NUM_FU).

Ports:
- clock  in  1: single clock, rising edge.
- reset  in  1: asynchronous, active-low reset (asserted when 0).
- flush_in  in  1: mispredict recovery; drop all grants this cycle and null the CDBs next cycle.
- fu_valid_in  in  NUM_FU: FU i has a completed result pending.
- fu_tag_in  in  NUM_FU*8: ROB tag per FU; FU i occupies bits [8i+7:8i].
- fu_value_in  in  NUM_FU*64: result value per FU; FU i occupies bits [64i+63:64i].
- fu_mispredicted_in  in  NUM_FU: branch-mispredict flag per FU.
- fu_ready_out  out  NUM_FU: combinational grant; a transfer occurs when valid and ready are both high in the same cycle.
- cdb1_tag_out  out  8: CDB1 tag (8'hFF = null).
- cdb1_value_out  out  64: CDB1 value.
- cdb1_mispredicted_out  out  1: CDB1 mispredict flag.
- cdb2_tag_out  out  8: CDB2 tag (8'hFF = null).
- cdb2_value_out  out  64: CDB2 value.
- cdb2_mispredicted_out  out  1: CDB2 mispredict flag.
- busy_out  out  1: registered; 1 if any CDB output carried a non-null tag this cycle.

Behaviour:
- Reset (reset==0, async):
  - cdb*_tag_out=8'hFF, cdb*_value_out=0, cdb*_mispredicted_out=0.
  - busy_out=0, rr_ptr=0.
  - fu_ready_out=0 while reset is held.
- Eligibility: FU i is eligible when fu_valid_in[i]=1 and its tag != 8'hFF. A valid request with tag 8'hFF is ignored and never readied.
- Arbitration is combinational each cycle:
  - Scan eligible FUs starting at rr_ptr, ascending, modulo NUM_FU.
  - First hit becomes grant A and drives CDB1; second hit becomes grant B and drives CDB2.
  - At most two ready bits are high per cycle.
  - FUs not granted must hold valid and data stable until readied.
- Latency: a result granted in cycle N appears on the CDB outputs in cycle N+1, for exactly one cycle. Outputs are registered.
- Single grant: the result goes on CDB1; CDB2 tag=8'hFF, value=0, mispredicted=0.
- No grant: both CDBs null next cycle.
- rr_ptr update on the clock edge:
  - Two grants: rr_ptr = (index of B)+1 mod NUM_FU.
  - One grant: rr_ptr = (index of A)+1 mod NUM_FU.
  - No grant: rr_ptr unchanged.
  - Wrap from NUM_FU-1 to 0 is explicit.
- flush_in=1 (synchronous):
  - fu_ready_out=0 that cycle.
  - Both CDBs null next cycle.
  - rr_ptr unchanged.
  - Flush overrides all grants in the same cycle.
- Duplicate tags from two FUs in one cycle are not checked; both are granted per the normal rules.
- busy_out = registered OR of the two next-cycle "tag != 8'hFF" conditions.
- Reset asserted mid-operation: outputs go null immediately; no partially broadcast result survives.

Optional Feature:
- Macro: CDB_MISPRED_PRIORITY_EN.
- When defined:
  - Eligible requests with fu_mispredicted_in=1 are scanned first (round-robin order among themselves), then the remaining eligible requests.
  - A mispredicted result therefore always takes CDB1 when any is present.
  - rr_ptr still advances past the last granted index.
- When undefined: pure round-robin, and fu_mispredicted_in does not affect arbitration.

Test Plan (NUM_FU=4):
1. Reset released, all valid=0 -> ready=0000; both CDB tags 8'hFF; busy_out=0; rr_ptr=0.
2. rr_ptr=0, valid=1011, tags 3/7/-/9 -> ready=0011. Next cycle: CDB1 tag 3, CDB2 tag 7; rr_ptr=2. Then FU3 (tag 9) is granted on CDB1, CDB2 is null, and rr_ptr=0.
3. rr_ptr=3, valid=1001 with tags 0x12 (FU0) and 0x1F (FU3) -> CDB1=0x1F (FU3), CDB2=0x12 (FU0); rr_ptr wraps to 1.
4. valid=1111 with flush_in=1 -> ready=0000; CDBs null next cycle; rr_ptr unchanged. Next cycle with flush_in=0: two grants resume from the same rr_ptr.
5. FU2 valid with tag 8'hFF, FU1 valid with tag 5 -> only FU1 is readied; CDB1 tag 5, CDB2 null.
6. With CDB_MISPRED_PRIORITY_EN: rr_ptr=0, valid=0101, FU2 mispredicted=1 -> CDB1=FU2 with mispredicted_out=1, CDB2=FU0. Without the macro: CDB1=FU0, CDB2=FU2.
